// File: rtl/rtr_eject_endpoint_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rtr_eject_endpoint_pkg
// Description : Shared constants, field layout helpers and FSM encoding for
//               the router ejection endpoint.
// Revision    : 1.0 - initial release
// ============================================================================
package rtr_eject_endpoint_pkg;

    localparam int C_NUM_VCS         = 4;
    localparam int C_VC_BUFFER_DEPTH = 8;
    localparam int C_FLIT_DATA_WIDTH = 64;

    // Channel layout, MSB to LSB: {valid, vc, head, tail, data}
    function automatic int ch_tail_pos(input int fdw);
        return fdw;
    endfunction

    function automatic int ch_head_pos(input int fdw);
        return fdw + 1;
    endfunction

    function automatic int ch_vc_lsb(input int fdw);
        return fdw + 2;
    endfunction

    function automatic int ch_valid_pos(input int fdw, input int viw);
        return fdw + 2 + viw;
    endfunction

    // flow_ctrl layout: {credit_valid, credit_vc}
    function automatic int fc_valid_pos(input int viw);
        return viw;
    endfunction

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    localparam int C_ERR_HEAD_IN_PKT  = 0;
    localparam int C_ERR_BODY_NO_PKT  = 1;
    localparam int C_ERR_OVERFLOW     = 2;
    localparam int C_ERR_BITS         = 3;

endpackage
`default_nettype wire

// File: rtl/rtr_eject_vc_fifo.sv
`default_nettype none
// ============================================================================
// Module      : rtr_eject_vc_fifo
// Description : Single-VC flit FIFO; a pop frees a slot for a same-cycle push.
// Revision    : 1.0 - initial release
// ============================================================================
module rtr_eject_vc_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 66
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic             overflow
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_pop;
    logic             w_do_push;

    assign full      = (r_count == CNT_W'(DEPTH));
    assign empty     = (r_count == '0);
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);
    assign overflow  = push && full && !w_do_pop;
    assign dout      = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

endmodule
`default_nettype wire

// File: rtl/rtr_eject_endpoint.sv
`default_nettype none
// ============================================================================
// Module      : rtr_eject_endpoint
// Description : Credit-based link receiver; buffers flits per VC and hands
//               whole packets to the node. Optional: RTR_EJECT_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module rtr_eject_endpoint
    import rtr_eject_endpoint_pkg::*;
#(
    parameter int NUM_VCS         = C_NUM_VCS,
    parameter int VC_IDX_WIDTH    = $clog2(NUM_VCS),
    parameter int VC_BUFFER_DEPTH = C_VC_BUFFER_DEPTH,
    parameter int FLIT_DATA_WIDTH = C_FLIT_DATA_WIDTH,
    parameter int CHANNEL_WIDTH   = 1 + VC_IDX_WIDTH + 2 + FLIT_DATA_WIDTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [CHANNEL_WIDTH-1:0]   channel_in,
    output logic [VC_IDX_WIDTH:0]      flow_ctrl_out,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [VC_IDX_WIDTH-1:0]    out_vc,
    output logic                       out_head,
    output logic                       out_tail,
    output logic [FLIT_DATA_WIDTH-1:0] out_data,
`ifdef RTR_EJECT_STATS_EN
    output logic [31:0]                pkt_count,
    output logic [31:0]                flit_count,
`endif
    output logic                       error
);

    localparam int VIW       = VC_IDX_WIDTH;
    localparam int FLIT_W    = FLIT_DATA_WIDTH + 2;
    localparam int TAIL_POS  = ch_tail_pos(FLIT_DATA_WIDTH);
    localparam int HEAD_POS  = ch_head_pos(FLIT_DATA_WIDTH);
    localparam int VC_LSB    = ch_vc_lsb(FLIT_DATA_WIDTH);
    localparam int VALID_POS = ch_valid_pos(FLIT_DATA_WIDTH, VIW);

    logic              w_in_valid;
    logic [VIW-1:0]    w_in_vc;
    logic              w_in_head;
    logic              w_in_tail;
    logic [FLIT_W-1:0] w_in_flit;

    logic [NUM_VCS-1:0] w_push;
    logic [NUM_VCS-1:0] w_pop;
    logic [NUM_VCS-1:0] w_accept;
    logic [NUM_VCS-1:0] w_full;
    logic [NUM_VCS-1:0] w_empty;
    logic [NUM_VCS-1:0] w_ovf;
    logic [FLIT_W-1:0]  w_head_flit [NUM_VCS];

    state_t            r_state;
    state_t            w_state_nxt;
    logic [VIW-1:0]    r_lock_vc;
    logic [VIW-1:0]    w_lock_nxt;
    logic [VIW-1:0]    r_rr_ptr;
    logic [VIW-1:0]    w_rr_nxt;
    logic [VIW-1:0]    w_sel_vc;
    logic [VIW-1:0]    w_cand;
    logic              w_found;
    logic              w_out_valid;
    logic              w_xfer;
    logic [FLIT_W-1:0] w_sel_flit;

    logic [NUM_VCS-1:0]    r_in_pkt;
    logic [C_ERR_BITS-1:0] r_err_cause;
    logic [VIW:0]          r_flow_ctrl;

    // Stored flit is {head, tail, data}, i.e. the low bits of the channel
    assign w_in_valid = channel_in[VALID_POS];
    assign w_in_vc    = channel_in[VC_LSB +: VIW];
    assign w_in_head  = channel_in[HEAD_POS];
    assign w_in_tail  = channel_in[TAIL_POS];
    assign w_in_flit  = channel_in[FLIT_W-1:0];

    for (genvar g = 0; g < NUM_VCS; g++) begin : g_vc
        assign w_push[g]   = w_in_valid && (w_in_vc == VIW'(g));
        assign w_pop[g]    = w_xfer && (w_sel_vc == VIW'(g));
        assign w_accept[g] = w_push[g] && (!w_full[g] || w_pop[g]);

        rtr_eject_vc_fifo #(
            .DEPTH (VC_BUFFER_DEPTH),
            .WIDTH (FLIT_W)
        ) u_fifo (
            .clk      (clk),
            .reset    (reset),
            .push     (w_push[g]),
            .pop      (w_pop[g]),
            .din      (w_in_flit),
            .dout     (w_head_flit[g]),
            .full     (w_full[g]),
            .empty    (w_empty[g]),
            .overflow (w_ovf[g])
        );
    end

    // Descending scan so the candidate nearest the round-robin pointer wins
    always_comb begin
        w_state_nxt = r_state;
        w_lock_nxt  = r_lock_vc;
        w_rr_nxt    = r_rr_ptr;
        w_sel_vc    = r_lock_vc;
        w_cand      = '0;
        w_found     = 1'b0;
        if (r_state == ST_IDLE) begin
            for (int i = NUM_VCS - 1; i >= 0; i--) begin
                w_cand = r_rr_ptr + VIW'(i);
                if (!w_empty[w_cand] && w_head_flit[w_cand][HEAD_POS]) begin
                    w_found  = 1'b1;
                    w_sel_vc = w_cand;
                end
            end
            w_out_valid = w_found;
        end else begin
            w_out_valid = !w_empty[r_lock_vc];
        end
        w_xfer     = w_out_valid && out_ready;
        w_sel_flit = w_head_flit[w_sel_vc];
        if (w_out_valid) begin
            w_state_nxt = ST_LOCKED;
            w_lock_nxt  = w_sel_vc;
            if (w_xfer && w_sel_flit[TAIL_POS]) begin
                w_state_nxt = ST_IDLE;
                w_rr_nxt    = w_sel_vc + VIW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_lock_vc   <= '0;
            r_rr_ptr    <= '0;
            r_flow_ctrl <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_lock_vc   <= w_lock_nxt;
            r_rr_ptr    <= w_rr_nxt;
            r_flow_ctrl <= {w_xfer, (w_xfer ? w_sel_vc : VIW'(0))};
        end
    end

    // Packet framing tracks only flits that actually land in a FIFO
    always_ff @(posedge clk) begin
        if (reset) begin
            r_in_pkt    <= '0;
            r_err_cause <= '0;
        end else begin
            if (w_in_valid) begin
                if (w_in_head && r_in_pkt[w_in_vc]) begin
                    r_err_cause[C_ERR_HEAD_IN_PKT] <= 1'b1;
                end
                if (!w_in_head && !r_in_pkt[w_in_vc]) begin
                    r_err_cause[C_ERR_BODY_NO_PKT] <= 1'b1;
                end
                if (w_accept[w_in_vc]) begin
                    if (w_in_head) begin
                        r_in_pkt[w_in_vc] <= !w_in_tail;
                    end else if (w_in_tail) begin
                        r_in_pkt[w_in_vc] <= 1'b0;
                    end
                end
            end
            if (|w_ovf) begin
                r_err_cause[C_ERR_OVERFLOW] <= 1'b1;
            end
        end
    end

    assign flow_ctrl_out = r_flow_ctrl;
    assign out_valid     = w_out_valid;
    assign out_vc        = w_sel_vc;
    assign out_head      = w_sel_flit[HEAD_POS];
    assign out_tail      = w_sel_flit[TAIL_POS];
    assign out_data      = w_sel_flit[FLIT_DATA_WIDTH-1:0];
    assign error         = |r_err_cause;

`ifdef RTR_EJECT_STATS_EN
    logic [31:0] r_pkt_count;
    logic [31:0] r_flit_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pkt_count  <= '0;
            r_flit_count <= '0;
        end else if (w_xfer) begin
            r_flit_count <= r_flit_count + 32'd1;
            if (w_sel_flit[TAIL_POS]) begin
                r_pkt_count <= r_pkt_count + 32'd1;
            end
        end
    end

    assign pkt_count  = r_pkt_count;
    assign flit_count = r_flit_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rtr_eject_endpoint.sv
`default_nettype none
// ============================================================================
// Module      : tb_rtr_eject_endpoint
// Description : Directed plus random bench for rtr_eject_endpoint against a
//               queue-based packet model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rtr_eject_endpoint;

    localparam int NV    = 4;
    localparam int VIW   = 2;
    localparam int DEPTH = 8;
    localparam int FDW   = 64;
    localparam int CW    = 1 + VIW + 2 + FDW;

    typedef struct packed {
        logic           head;
        logic           tail;
        logic [FDW-1:0] data;
    } flit_t;

    logic           clk = 1'b0;
    logic           reset;
    logic [CW-1:0]  channel_in;
    logic [VIW:0]   flow_ctrl_out;
    logic           out_valid;
    logic           out_ready;
    logic [VIW-1:0] out_vc;
    logic           out_head;
    logic           out_tail;
    logic [FDW-1:0] out_data;
    logic           error;
`ifdef RTR_EJECT_STATS_EN
    logic [31:0]    pkt_count;
    logic [31:0]    flit_count;
`endif

    always #5 clk = ~clk;

    rtr_eject_endpoint dut (
        .clk           (clk),
        .reset         (reset),
        .channel_in    (channel_in),
        .flow_ctrl_out (flow_ctrl_out),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_vc        (out_vc),
        .out_head      (out_head),
        .out_tail      (out_tail),
        .out_data      (out_data),
`ifdef RTR_EJECT_STATS_EN
        .pkt_count     (pkt_count),
        .flit_count    (flit_count),
`endif
        .error         (error)
    );

    // Reference model: per-VC queues, packet owner, round-robin start
    flit_t        q [NV][$];
    bit           in_pkt [NV];
    bit           m_err;
    int           owner;
    int           rr;
    logic [VIW:0] m_fc;
    int unsigned  m_pkts;
    int unsigned  m_flits;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < NV; i++) begin
            q[i].delete();
            in_pkt[i] = 1'b0;
        end
        m_err   = 1'b0;
        owner   = -1;
        rr      = 0;
        m_fc    = '0;
        m_pkts  = 0;
        m_flits = 0;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        channel_in = '0;
        out_ready  = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_reset();
    endtask

    task automatic cycle(input bit v, input int vc, input bit h, input bit t,
                         input logic [63:0] d, input bit rdy);
        bit    ev;
        int    ev_vc;
        flit_t ef;
        bit    xfer;
        channel_in = {v, VIW'(vc), h, t, d};
        out_ready  = rdy;
        #3;
        ev    = 1'b0;
        ev_vc = 0;
        if (owner >= 0) begin
            ev_vc = owner;
            ev    = (q[owner].size() > 0);
        end else begin
            for (int i = 0; i < NV; i++) begin
                int c;
                c = (rr + i) % NV;
                if (!ev && q[c].size() > 0 && q[c][0].head) begin
                    ev    = 1'b1;
                    ev_vc = c;
                end
            end
        end
        chk("out_valid", 64'(out_valid), 64'(ev));
        if (ev) begin
            ef = q[ev_vc][0];
            chk("out_vc",   64'(out_vc),   64'(ev_vc));
            chk("out_head", 64'(out_head), 64'(ef.head));
            chk("out_tail", 64'(out_tail), 64'(ef.tail));
            chk("out_data", out_data,      ef.data);
        end
        chk("flow_ctrl", 64'(flow_ctrl_out), 64'(m_fc));
        chk("error",     64'(error),         64'(m_err));
`ifdef RTR_EJECT_STATS_EN
        chk("pkt_count",  64'(pkt_count),  64'(m_pkts));
        chk("flit_count", 64'(flit_count), 64'(m_flits));
`endif
        xfer = ev && rdy;
        @(posedge clk);
        m_fc = xfer ? {1'b1, VIW'(ev_vc)} : '0;
        if (xfer) begin
            ef = q[ev_vc].pop_front();
            m_flits++;
            if (ef.tail) begin
                m_pkts++;
                owner = -1;
                rr    = (ev_vc + 1) % NV;
            end else begin
                owner = ev_vc;
            end
        end else if (ev) begin
            owner = ev_vc;
        end
        if (v) begin
            if (h && in_pkt[vc])   m_err = 1'b1;
            if (!h && !in_pkt[vc]) m_err = 1'b1;
            if (q[vc].size() >= DEPTH) begin
                m_err = 1'b1;
            end else begin
                q[vc].push_back({h, t, d});
                if (h)      in_pkt[vc] = !t;
                else if (t) in_pkt[vc] = 1'b0;
            end
        end
        #1;
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) cycle(1'b0, 0, 1'b0, 1'b0, 64'h0, rdy);
    endtask

    initial begin
        bit          h;
        bit          t;
        int          vc;
        logic [63:0] d;

        do_reset();
        chk("rst_fc",    64'(flow_ctrl_out), 64'h0);
        chk("rst_valid", 64'(out_valid),     64'h0);
        chk("rst_error", 64'(error),         64'h0);

        // 3-flit packet on VC2 with the node always ready
        cycle(1, 2, 1, 0, 64'hA1, 1);
        cycle(1, 2, 0, 0, 64'hA2, 1);
        cycle(1, 2, 0, 1, 64'hA3, 1);
        idle(3, 1);

        // Interleaved arrival must come out as whole packets
        cycle(1, 0, 1, 0, 64'hB0, 0);
        cycle(1, 1, 1, 0, 64'hC0, 0);
        cycle(1, 0, 0, 1, 64'hB1, 0);
        cycle(1, 1, 0, 1, 64'hC1, 0);
        idle(6, 1);
        // Pointer now sits at 2, so VC3 must beat VC1
        cycle(1, 1, 1, 1, 64'hD1, 0);
        cycle(1, 3, 1, 1, 64'hD3, 0);
        idle(4, 1);

        // Full VC2 with simultaneous push and pop
        cycle(1, 2, 1, 0, 64'hE0, 0);
        for (int i = 1; i < DEPTH; i++) cycle(1, 2, 0, 0, 64'hE0 + 64'(i), 0);
        cycle(1, 2, 0, 0, 64'hE8, 1);
        cycle(1, 2, 0, 1, 64'hE9, 1);
        chk("full_pushpop_no_err", 64'(error), 64'h0);
        idle(DEPTH + 3, 1);

        // Overflow on VC1
        cycle(1, 1, 1, 0, 64'hF0, 0);
        for (int i = 1; i < DEPTH; i++) cycle(1, 1, 0, 0, 64'hF0 + 64'(i), 0);
        cycle(1, 1, 0, 0, 64'hFF, 0);
        idle(1, 0);
        chk("overflow_err", 64'(error), 64'h1);
        idle(DEPTH + 2, 1);
        cycle(1, 1, 0, 1, 64'hF9, 1);
        idle(2, 1);

        // Body flit without a head, then a legal packet on VC0
        do_reset();
        cycle(1, 3, 0, 0, 64'h33, 1);
        idle(1, 1);
        chk("proto_err", 64'(error), 64'h1);
        cycle(1, 0, 1, 0, 64'h40, 1);
        cycle(1, 0, 0, 1, 64'h41, 1);
        idle(3, 1);
        chk("proto_err_sticky", 64'(error), 64'h1);

        // Reset in the middle of a buffered packet
        do_reset();
        cycle(1, 0, 1, 0, 64'h50, 0);
        cycle(1, 0, 0, 0, 64'h51, 0);
        do_reset();
        chk("midrst_valid", 64'(out_valid),     64'h0);
        chk("midrst_fc",    64'(flow_ctrl_out), 64'h0);
        chk("midrst_error", 64'(error),         64'h0);
        cycle(1, 0, 1, 0, 64'h60, 1);
        cycle(1, 0, 0, 0, 64'h61, 1);
        cycle(1, 0, 0, 0, 64'h62, 1);
        cycle(1, 0, 0, 1, 64'h63, 1);
        idle(3, 1);

        // Five single-flit packets
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1, i % NV, 1, 1, 64'h70 + 64'(i), 1);
        idle(3, 1);
`ifdef RTR_EJECT_STATS_EN
        chk("stats_pkts",  64'(pkt_count),  64'd5);
        chk("stats_flits", 64'(flit_count), 64'd5);
`endif

        // Random legal traffic with random backpressure
        do_reset();
        for (int n = 0; n < 500; n++) begin
            vc = int'($urandom_range(0, NV - 1));
            d  = {$urandom, $urandom};
            if ($urandom_range(0, 3) != 0 && q[vc].size() < DEPTH) begin
                if (in_pkt[vc]) begin
                    h = 1'b0;
                    t = ($urandom_range(0, 2) == 0);
                end else begin
                    h = 1'b1;
                    t = ($urandom_range(0, 3) == 0);
                end
                cycle(1'b1, vc, h, t, d, $urandom_range(0, 2) != 0);
            end else begin
                cycle(1'b0, 0, 1'b0, 1'b0, d, $urandom_range(0, 2) != 0);
            end
        end
        idle(40, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
